// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and GF(2^8) helpers for the AES-128 inverse
//               cipher core: FSM state encoding, round constants, S-boxes,
//               key-schedule steps and inverse state transforms.
//               Byte 0 of a 128-bit block is [127:120]; bytes are
//               column-major (byte index = column*4 + row).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FIN    = 3'd4
    } fsm_state_e;

    // Round constants for rounds 1..10 (index 0 = round 1).
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Out-of-range indices return 0 so that counter wrap cannot index
    // past the table.
    function automatic logic [7:0] rcon_at(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (idx == 4'(i)) r = RCON[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0,
    // which is exactly what the S-box definition needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // S-boxes are computed from their algebraic definition rather than
    // stored as tables; the synthesiser flattens them into logic.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // K(r-1) -> Kr
    function automatic logic [127:0] key_step_fwd(input logic [127:0] k,
                                                  input logic [7:0]   rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Kr -> K(r-1); rc is the constant that produced Kr.
    function automatic logic [127:0] key_step_inv(input logic [127:0] k,
                                                  input logic [7:0]   rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(c*4 + row) -: 8] = s[127 - 8*(((c - row + 4) % 4)*4 + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
            };
        end
        return r;
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_round
// Description : Combinational inverse AES round:
//               InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//               i_final bypasses InvMixColumns on o_state (last round);
//               o_bypass always carries the value before InvMixColumns.
// Ports       : i_state      128  current cipher state
//               i_round_key  128  round key Kr
//               i_final      1    1 = bypass InvMixColumns on o_state
//               o_state      128  round result (mix applied unless i_final)
//               o_bypass     128  round result without InvMixColumns
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final,
    output logic [127:0] o_state,
    output logic [127:0] o_bypass
);

    logic [127:0] w_added;
    logic [127:0] w_mixed;

    assign w_added  = inv_sub_bytes(inv_shift_rows(i_state)) ^ i_round_key;
    assign w_mixed  = inv_mix_columns(w_added);
    assign o_bypass = w_added;
    assign o_state  = i_final ? w_added : w_mixed;

endmodule : aes_inv_round
`default_nettype wire

// File: rtl/aes128_inv_core.sv
`default_nettype none
// ============================================================================
// Module      : aes128_inv_core
// Description : Iterative AES-128 decryption core, one round per clock.
//               Expands the key forward to K10, then walks the key schedule
//               backwards while running the inverse rounds. With
//               KEY_CACHE_EN=1 the last K10 is kept so a block under the
//               same key can skip expansion (reuse_key_i).
// Ports       : clk            1    clock, rising edge
//               rst            1    synchronous active-high reset
//               start_i        1    request, accepted when ready_o=1
//               reuse_key_i    1    use cached K10 if valid
//               key_i          128  cipher key
//               cipher_text_i  128  ciphertext block
//               plain_text_o   128  result, held until next done_o
//               ready_o        1    idle, can accept start_i
//               done_o         1    one-cycle pulse, plain_text_o valid
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_inv_core
    import aes_pkg::*;
#(
    parameter bit KEY_CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         reuse_key_i,
    input  logic [127:0] key_i,
    input  logic [127:0] cipher_text_i,
    output logic [127:0] plain_text_o,
    output logic         ready_o,
    output logic         done_o
);

    fsm_state_e   r_fsm;
    fsm_state_e   w_fsm_next;

    logic [127:0] r_state;
    logic [127:0] r_round_key;
    logic [127:0] r_plain;
    logic [3:0]   r_round;
    logic         r_ready;
    logic         r_done;
    logic [127:0] r_k10_cache;
    logic         r_key_valid;

    logic         w_accept;
    logic         w_cache_hit;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_inv;
    logic [127:0] w_rnd_state;
    logic [127:0] w_rnd_bypass;

    assign w_accept    = (r_fsm == S_IDLE) && start_i && r_ready;
    assign w_cache_hit = KEY_CACHE_EN && reuse_key_i && r_key_valid;

    // r_round counts 0..9 during expansion and 10..1 while decrypting, so
    // the forward step uses RCON[r_round] and the inverse step (Kr -> K(r-1))
    // uses RCON[r_round-1] with a single counter.
    assign w_key_fwd = key_step_fwd(r_round_key, rcon_at(r_round));
    assign w_key_inv = key_step_inv(r_round_key, rcon_at(r_round - 4'd1));

    aes_inv_round u_round (
        .i_state     (r_state),
        .i_round_key (r_round_key),
        .i_final     (r_fsm == S_FIN),
        .o_state     (w_rnd_state),
        .o_bypass    (w_rnd_bypass)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:   if (w_accept) w_fsm_next = w_cache_hit ? S_INIT : S_KEYEXP;
            S_KEYEXP: if (r_round == 4'd9) w_fsm_next = S_INIT;
            S_INIT:   w_fsm_next = S_ROUND;
            S_ROUND:  if (r_round == 4'd1) w_fsm_next = S_FIN;
            S_FIN:    w_fsm_next = S_IDLE;
            default:  w_fsm_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= '0;
            r_round_key <= '0;
            r_plain     <= '0;
            r_round     <= 4'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= cipher_text_i;
                        r_ready <= 1'b0;
                        if (w_cache_hit) begin
                            r_round_key <= r_k10_cache;
                            r_round     <= 4'd10;
                        end else begin
                            r_round_key <= key_i;
                            r_round     <= 4'd0;
                        end
                    end
                end
                S_KEYEXP: begin
                    r_round_key <= w_key_fwd;
                    r_round     <= r_round + 4'd1;
                end
                S_INIT: begin
                    r_state     <= r_state ^ r_round_key;
                    r_round_key <= w_key_inv;
                    r_round     <= 4'd9;
                end
                S_ROUND: begin
                    r_state     <= w_rnd_state;
                    r_round_key <= w_key_inv;
                    r_round     <= r_round - 4'd1;
                end
                S_FIN: begin
                    r_plain <= w_rnd_bypass;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // K10 cache: written on the final expansion step, cleared only by reset
    // ------------------------------------------------------------------
    generate
        if (KEY_CACHE_EN) begin : g_cache
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_k10_cache <= '0;
                    r_key_valid <= 1'b0;
                end else if (r_fsm == S_KEYEXP && r_round == 4'd9) begin
                    r_k10_cache <= w_key_fwd;
                    r_key_valid <= 1'b1;
                end
            end
        end else begin : g_no_cache
            always_ff @(posedge clk) begin
                r_k10_cache <= '0;
                r_key_valid <= 1'b0;
            end
        end
    endgenerate

    assign plain_text_o = r_plain;
    assign ready_o      = r_ready;
    assign done_o       = r_done;

endmodule : aes128_inv_core
`default_nettype wire
